// File: rtl/seq_alu_pkg.sv
// Shared opcode/state definitions for seq_alu.
// OP_LAST_LEGAL follows SEQ_ALU_DIV_EN: opcode 8 is legal only when the divider is built.
package seq_alu_pkg;

  localparam logic [3:0] OPC_ADD = 4'd0;
  localparam logic [3:0] OPC_SUB = 4'd1;
  localparam logic [3:0] OPC_AND = 4'd2;
  localparam logic [3:0] OPC_OR  = 4'd3;
  localparam logic [3:0] OPC_XOR = 4'd4;
  localparam logic [3:0] OPC_SHL = 4'd5;
  localparam logic [3:0] OPC_SHR = 4'd6;
  localparam logic [3:0] OPC_MUL = 4'd7;
  localparam logic [3:0] OPC_DIV = 4'd8;

`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_LAST_LEGAL = OPC_DIV;
`else
  localparam logic [3:0] OP_LAST_LEGAL = OPC_MUL;
`endif

  typedef enum logic [3:0] {
    OP_ADD = OPC_ADD,
    OP_SUB = OPC_SUB,
    OP_AND = OPC_AND,
    OP_OR  = OPC_OR,
    OP_XOR = OPC_XOR,
    OP_SHL = OPC_SHL,
    OP_SHR = OPC_SHR,
    OP_MUL = OPC_MUL,
    OP_DIV = OPC_DIV
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine: shift-add multiply, and restoring divide when SEQ_ALU_DIV_EN is defined.
// Loads on i_start, advances one bit per i_step; o_last flags the final step.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_step,
`ifdef SEQ_ALU_DIV_EN
  input  logic             i_is_div,
`endif
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_nxt;
`ifdef SEQ_ALU_DIV_EN
  logic               r_is_div;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_nxt;
`endif

  // One iteration: acc holds {hi, lo} = {partial product, multiplier} or {remainder, quotient}
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_nxt     = {w_mul_sum, r_acc[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, r_b};
    if (w_rem_sh >= {1'b0, r_b}) begin
      w_div_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_div_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
    if (r_is_div) begin
      w_nxt = w_div_nxt;
    end else begin
      w_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
`endif
  end

  // Working register and step counter; counter wraps to zero after the final step
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= {(2*WIDTH){1'b0}};
      r_b   <= {WIDTH{1'b0}};
      r_cnt <= {CW{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      r_is_div <= 1'b0;
`endif
    end else if (i_start) begin
      r_acc <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
      r_cnt <= {CW{1'b0}};
`ifdef SEQ_ALU_DIV_EN
      r_is_div <= i_is_div;
`endif
    end else if (i_step) begin
      r_acc <= w_nxt;
      r_cnt <= (r_cnt == LAST) ? {CW{1'b0}} : r_cnt + CW'(1);
    end
  end

  assign o_last = (r_cnt == LAST);
  assign o_lo   = r_acc[WIDTH-1:0];
  assign o_hi   = r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// seq_alu top: handshake FSM, single-cycle ops, flags and registered outputs.
// Define SEQ_ALU_DIV_EN to build the divider; otherwise opcode 8 is reported as illegal.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zero,
  output logic             o_carry,
  output logic             o_overflow,
  output logic             o_err
);
  localparam int SW = $clog2(WIDTH);

  alu_state_e       r_state, w_state_nxt;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_out_valid, r_zero, r_carry, r_overflow, r_err;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             w_accept, w_iter, w_last, w_step;
  logic [WIDTH-1:0] w_eng_lo, w_eng_hi, w_res, w_hi;
  logic [WIDTH:0]   w_sum, w_dif;
  logic             w_carry, w_ovf, w_err;

  assign o_in_ready = (r_state == ST_IDLE) && !i_rst;
  assign w_accept   = (r_state == ST_IDLE) && i_in_valid;
  assign w_step     = (r_state == ST_BUSY);
`ifdef SEQ_ALU_DIV_EN
  assign w_iter = (i_op == OPC_MUL) || ((i_op == OPC_DIV) && (i_b != {WIDTH{1'b0}}));
`else
  assign w_iter = (i_op == OPC_MUL);
`endif

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (w_accept && w_iter),
    .i_step   (w_step),
`ifdef SEQ_ALU_DIV_EN
    .i_is_div (i_op == OPC_DIV),
`endif
    .i_a      (i_a),
    .i_b      (i_b),
    .o_last   (w_last),
    .o_lo     (w_eng_lo),
    .o_hi     (w_eng_hi)
  );

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state; DONE is left only once the registered result has been taken
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_in_valid) w_state_nxt = w_iter ? ST_BUSY : ST_DONE;
        else            w_state_nxt = ST_IDLE;
      end
      ST_BUSY: begin
        if (w_last) w_state_nxt = ST_DONE;
        else        w_state_nxt = ST_BUSY;
      end
      ST_DONE: begin
        if (r_out_valid && i_out_ready) w_state_nxt = ST_IDLE;
        else                            w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Result and flag values computed from the latched operation
  always_comb begin
    w_res   = {WIDTH{1'b0}};
    w_hi    = {WIDTH{1'b0}};
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    w_sum   = {1'b0, r_a} + {1'b0, r_b};
    w_dif   = {1'b0, r_a} - {1'b0, r_b};
    if (r_op > OP_LAST_LEGAL) begin
      w_err = 1'b1;
    end else begin
      case (r_op)
        OP_ADD: begin
          w_res   = w_sum[WIDTH-1:0];
          w_carry = w_sum[WIDTH];
          w_ovf   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
        end
        OP_SUB: begin
          w_res   = w_dif[WIDTH-1:0];
          w_carry = w_dif[WIDTH];
          w_ovf   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
        end
        OP_AND: w_res = r_a & r_b;
        OP_OR:  w_res = r_a | r_b;
        OP_XOR: w_res = r_a ^ r_b;
        OP_SHL: w_res = r_a << r_b[SW-1:0];
        OP_SHR: w_res = r_a >> r_b[SW-1:0];
        OP_MUL: begin
          w_res = w_eng_lo;
          w_hi  = w_eng_hi;
          w_ovf = (w_eng_hi != {WIDTH{1'b0}});
        end
`ifdef SEQ_ALU_DIV_EN
        OP_DIV: begin
          if (r_b == {WIDTH{1'b0}}) begin
            w_res = {WIDTH{1'b1}};
            w_hi  = r_a;
            w_err = 1'b1;
          end else begin
            w_res = w_eng_lo;
            w_hi  = w_eng_hi;
          end
        end
`endif
        default: w_err = 1'b1;
      endcase
    end
  end

  // Operand latch and output registers; results load on the first DONE cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op        <= OP_ADD;
      r_a         <= {WIDTH{1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_result_hi <= {WIDTH{1'b0}};
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op <= alu_op_e'(i_op);
        r_a  <= i_a;
        r_b  <= i_b;
      end
      if ((r_state == ST_DONE) && !r_out_valid) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_result_hi <= w_hi;
        r_zero      <= (w_res == {WIDTH{1'b0}});
        r_carry     <= w_carry;
        r_overflow  <= w_ovf;
        r_err       <= w_err;
      end else if ((r_state == ST_DONE) && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_result    = r_result;
  assign o_result_hi = r_result_hi;
  assign o_zero      = r_zero;
  assign o_carry     = r_carry;
  assign o_overflow  = r_overflow;
  assign o_err       = r_err;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at WIDTH=8: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, zero, carry, overflow, err;
  logic [W-1:0] result, result_hi;

  seq_alu #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op(op), .i_a(a), .i_b(b), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_result_hi(result_hi), .o_zero(zero), .o_carry(carry),
    .o_overflow(overflow), .o_err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] res;
    logic [7:0] hi;
    logic       z, c, o, e;
    int         lat;
    int         acc;
    bit         seen;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] cap_res, cap_hi;
  logic       cap_z, cap_c, cap_o, cap_e;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
    end
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  function automatic exp_t model(input int opc, input int x, input int y);
    exp_t r;
    int s, p;
    r.res = 8'd0; r.hi = 8'd0; r.c = 1'b0; r.o = 1'b0; r.e = 1'b0;
    r.lat = 1; r.acc = 0; r.seen = 1'b0;
    case (opc)
      0: begin
        s = x + y; r.res = 8'(s % 256); r.c = (s > 255);
        s = sgn(x) + sgn(y); r.o = (s > 127) || (s < -128);
      end
      1: begin
        s = x - y + 256; r.res = 8'(s % 256); r.c = (x < y);
        s = sgn(x) - sgn(y); r.o = (s > 127) || (s < -128);
      end
      2: r.res = 8'(x & y);
      3: r.res = 8'(x | y);
      4: r.res = 8'(x ^ y);
      5: r.res = 8'((x * (1 << (y % 8))) % 256);
      6: r.res = 8'(x / (1 << (y % 8)));
      7: begin
        p = x * y; r.res = 8'(p % 256); r.hi = 8'(p / 256); r.o = (p > 255); r.lat = W + 1;
      end
`ifdef SEQ_ALU_DIV_EN
      8: begin
        if (y == 0) begin
          r.res = 8'd255; r.hi = 8'(x); r.e = 1'b1;
        end else begin
          r.res = 8'(x / y); r.hi = 8'(x % y); r.lat = W + 1;
        end
      end
`endif
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 8'd0);
    return r;
  endfunction

  // Every cycle the result is presented, it must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", 16'(out_valid), 16'd0);
      end else begin
        if (!exp_q[0].seen) begin
          chk("latency", 16'(cyc - exp_q[0].acc), 16'(exp_q[0].lat));
          exp_q[0].seen = 1'b1;
        end
        chk("result", 16'(result), 16'(exp_q[0].res));
        chk("result_hi", 16'(result_hi), 16'(exp_q[0].hi));
        chk("flags_zcoe", 16'({zero, carry, overflow, err}),
            16'({exp_q[0].z, exp_q[0].c, exp_q[0].o, exp_q[0].e}));
        chk("in_ready_while_done", 16'(in_ready), 16'd0);
      end
    end
  end

  task automatic run_op(input int opc, input int x, input int y, input int hold);
    exp_t e;
    int k;
    k = 0;
    while (in_ready !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    if (in_ready !== 1'b1) begin chk("in_ready_timeout", 16'd0, 16'd1); return; end
    e = model(opc, x, y);
    in_valid = 1'b1; op = 4'(opc); a = 8'(x); b = 8'(y);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.acc = cyc;
    exp_q.push_back(e);
    k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    if (out_valid !== 1'b1) begin
      chk("out_valid_timeout", 16'd0, 16'd1);
      void'(exp_q.pop_front());
      return;
    end
    cap_res = result; cap_hi = result_hi;
    cap_z = zero; cap_c = carry; cap_o = overflow; cap_e = err;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    void'(exp_q.pop_front());
    @(negedge clk);
    chk("release_in_ready", 16'(in_ready), 16'd1);
    chk("release_out_valid", 16'(out_valid), 16'd0);
  endtask

  initial begin
    int ro, ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 4'd0; a = 8'd0; b = 8'd0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 16'(out_valid), 16'd0);
    chk("reset_result", 16'({result_hi, result}), 16'd0);
    chk("reset_flags", 16'({zero, carry, overflow, err}), 16'd0);
    chk("reset_in_ready", 16'(in_ready), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", 16'(in_ready), 16'd1);

    run_op(0, 200, 100, 0);
    chk("add_result", 16'(cap_res), 16'd44);
    chk("add_zcoe", 16'({cap_z, cap_c, cap_o, cap_e}), 16'b0100);
    run_op(1, 5, 5, 0);
    chk("sub_eq_zc", 16'({cap_res, cap_z, cap_c}), 16'({8'd0, 1'b1, 1'b0}));
    run_op(1, 3, 5, 0);
    chk("sub_borrow", 16'({cap_res, cap_c}), 16'({8'hFE, 1'b1}));
    run_op(7, 255, 255, 0);
    chk("mul_product", {cap_hi, cap_res}, 16'hFE01);
    chk("mul_overflow", 16'(cap_o), 16'd1);
`ifdef SEQ_ALU_DIV_EN
    run_op(8, 200, 7, 0);
    chk("div_quot_rem", {cap_hi, cap_res}, 16'h041C);
    run_op(8, 9, 0, 0);
    chk("div0_result", {cap_hi, cap_res}, 16'h09FF);
    chk("div0_err", 16'(cap_e), 16'd1);
`else
    run_op(8, 200, 7, 0);
    chk("div_disabled", 16'({cap_res, cap_e}), 16'({8'd0, 1'b1}));
`endif
    run_op(12, 7, 3, 0);
    chk("illegal_op", 16'({cap_res, cap_hi, cap_z, cap_e}), 16'({8'd0, 8'd0, 1'b1, 1'b1}) >> 0);
    run_op(4, 8'hF0, 8'h3C, 5);
    chk("xor_backpressure", 16'(cap_res), 16'h00CC);
    run_op(5, 8'h81, 8'hF9, 0);
    chk("shl_masked_amount", 16'(cap_res), 16'h0002);

    // Reset during the fourth BUSY cycle of a multiply
    @(negedge clk);
    in_valid = 1'b1; op = 4'd7; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midmul_rst_out_valid", 16'(out_valid), 16'd0);
    chk("midmul_rst_outputs", {result_hi, result}, 16'd0);
    chk("midmul_rst_flags", 16'({zero, carry, overflow, err}), 16'd0);
    chk("midmul_rst_in_ready", 16'(in_ready), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(0, 1, 1, 0);
    chk("add_after_reset", 16'(cap_res), 16'd2);

    for (int i = 0; i < 150; i++) begin
      ro = $urandom_range(0, 15);
      if (ro > 9 && $urandom_range(0, 2) != 0) ro = $urandom_range(0, 8);
      ra = $urandom_range(0, 255);
      rb = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      run_op(ro, ra, rb, $urandom_range(0, 2));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle ALU with valid/ready handshakes on operand and result sides. Successor to the fixed-width combinational ALU in `tt_um_alu`. Adds:
- configurable datapath width
- an iterative unsigned multiplier and divider
- status flags and backpressure

It sits between the pin-level operand loader and the result serialiser inside the Tiny Tapeout wrapper.

## Interface
- `WIDTH`, default 8: operand/result width; power of two, ≥4.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand/opcode present.
- `in_ready` output 1: block accepts a new operation; high only in IDLE with `rst` low.
- `op` input 4: opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL, 8 DIV; 9–15 illegal.
- `a` input WIDTH: operand A, unsigned.
- `b` input WIDTH: operand B, unsigned.
- `out_valid` output 1: result, flags and `err` valid.
- `out_ready` input 1: consumer takes result.
- `result` output WIDTH: low result / quotient.
- `result_hi` output WIDTH: MUL product high half / DIV remainder; 0 for other ops.
- `zero` output 1: `result` == 0.
- `carry` output 1: ADD carry-out, SUB borrow (a < b); 0 otherwise.
- `overflow` output 1: ADD/SUB signed two's-complement overflow; MUL `result_hi` ≠ 0; 0 otherwise.
- `err` output 1: illegal opcode or divide by zero.

## Operation
- States: IDLE, BUSY, DONE.
- **Accept:** IDLE and `in_valid` at an edge.
  - `op`, `a` and `b` are latched.
  - Single-cycle ops, illegal ops and DIV with `b`=0 go to DONE.
  - MUL and DIV (`b`≠0) go to BUSY with step counter = 0.
- **BUSY:** one iteration per cycle.
  - MUL is shift-add over 2·WIDTH bits.
  - DIV is restoring, MSB first.
  - When the counter reaches WIDTH−1 the state goes to DONE. The counter wraps to 0 on entry to DONE.
- **DONE:** `out_valid`=1 and outputs are held stable until `out_ready`=1 at an edge, then IDLE. No new operation is accepted until then; operations never overlap.
- **Shifts:** SHL/SHR are logical, by `b[$clog2(WIDTH)-1:0]`. Upper bits of `b` are ignored.
- **ADD/SUB:** results wrap modulo 2^WIDTH.
- **Divide by zero:** `result` = all ones, `result_hi` = `a`, `err`=1.
- **Illegal opcode:** `result`=0, `result_hi`=0, `err`=1, all other flags 0 except `zero`=1.
- **Reset** (any state, including mid-BUSY): next state IDLE; any in-flight operation is discarded.
- Reset values: `out_valid`=0, `result`=0, `result_hi`=0, all flags 0. `in_ready`=0 while `rst` is high, and 1 in the cycle after `rst` falls.

## Timing
- **Single-cycle ops** (ADD–SHR, illegal, DIV by zero): accepted at edge N, `out_valid` high after edge N+1.
- **MUL / DIV:** accepted at edge N, `out_valid` high after edge N+WIDTH+1.
- **Release:** `out_ready` high at edge M in DONE gives `in_ready` high after M. The earliest next accept is edge M+1.
- `in_ready` is a combinational decode of state; it has no combinational path from `in_valid` or `out_ready`.
- All outputs other than `in_ready` are registered.

## Configuration
- `SEQ_ALU_DIV_EN` defined:
  - DIV datapath compiled in.
  - Opcode 8 behaves as specified above.
- `SEQ_ALU_DIV_EN` undefined:
  - Divider logic is absent.
  - Opcode 8 is treated as illegal: single-cycle, `err`=1, `result`=0.
  - MUL is unaffected.

## Structure
- **Package `seq_alu_pkg`:**
  - opcode enum `alu_op_e` (4 bits)
  - state enum `alu_state_e`
  - opcode localparams
  - `OP_LAST_LEGAL`, whose value depends on `SEQ_ALU_DIV_EN`
- **Sub-module `seq_alu_muldiv`:**
  - iterative MUL/DIV engine, parametrised by `WIDTH`
  - start, step-counter and done interface
  - owns the 2·WIDTH working register
- **Top `seq_alu`:** handshake FSM, single-cycle logic, flag generation and output registers.

## Test plan
All scenarios at `WIDTH`=8.
- **ADD:** `a`=200, `b`=100 → `result`=44, `carry`=1, `overflow`=0, `zero`=0. `out_valid` asserted 1 cycle after accept.
- **SUB:** `a`=5, `b`=5 → `result`=0, `zero`=1, `carry`=0. Then `a`=3, `b`=5 → `result`=0xFE, `carry`=1.
- **MUL:** `a`=0xFF, `b`=0xFF → `result_hi`=0xFE, `result`=0x01, `overflow`=1. `out_valid` asserted exactly 9 cycles after accept.
- **DIV** (with `SEQ_ALU_DIV_EN`): `a`=200, `b`=7 → `result`=28, `result_hi`=4, 9-cycle latency. Then `a`=9, `b`=0 → `result`=0xFF, `result_hi`=9, `err`=1, 1-cycle latency. Without the macro, `op`=8 → `err`=1, `result`=0.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after an XOR 0xF0^0x3C → `result`=0xCC stays stable and `in_ready`=0. Raise `out_ready` → `in_ready`=1 the next cycle; a new op is accepted.
- **Reset mid-MUL:** assert `rst` on the 4th BUSY cycle → next cycle `out_valid`=0 and outputs are zero. After `rst` falls, ADD 1+1 → `result`=2 with normal latency.
